mac_dot_pipe: RTL and testbench

- Parametrised successor to the single-lane accumulate block.
- Each accepted beat carries LANES operand pairs; the block multiplies them, sums the products, and accumulates the sum over a vector of beats delimited by in_last.
- It then presents one result per vector on a valid/ready output.
- Sits between operand staging buffers and the result writeback path of the compute datapath.

---
 rtl/mac_dot_pipe_if.sv | 31 +++
 rtl/mac_dot_pipe.sv | 172 +++++++++++++++++
 tb/tb_mac_dot_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_pipe_if.sv
// Operand/result handshake bundle for mac_dot_pipe.
// master: the environment (drives beats, accepts results).
// slave : the mac_dot_pipe datapath.
interface mac_dot_pipe_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_a;
  logic [LANES*DATA_W-1:0]   in_b;
  logic                      in_last;
  logic                      in_signed;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          out_result;
  logic [CNT_W-1:0]          out_count;
  logic                      out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, in_signed, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, in_signed, out_ready,
    output in_ready, out_valid, out_result, out_count, out_ovf
  );
endinterface

// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: LANES-wide multiply / adder-tree / accumulate over a vector of
// beats delimited by in_last, one result per vector on a valid/ready output.
// Stage 1 registers the lane products, stage 2 reduces and accumulates.
// Optional macro MAC_DOT_SAT_EN: accumulator clamps on overflow instead of
// wrapping (out_ovf is reported either way).
module mac_dot_pipe #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  mac_dot_pipe_if.slave   bus
);
  localparam int PW = 2 * DATA_W;

  if (ACC_W < 2 * DATA_W + $clog2(LANES)) begin : g_acc_w_check
    $error("mac_dot_pipe: ACC_W is too narrow for DATA_W and LANES");
  end
  if ((LANES < 1) || ((LANES & (LANES - 1)) != 0)) begin : g_lanes_check
    $error("mac_dot_pipe: LANES must be a power of two");
  end

  // Full-precision lane product in the selected number format.
  function automatic logic [PW-1:0] mul_lane(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic s);
    logic signed [PW-1:0] ps;
    logic        [PW-1:0] pu;
    ps = PW'($signed(a)) * PW'($signed(b));
    pu = PW'(a) * PW'(b);
    return s ? ps : pu;
  endfunction

  // Widen a product to accumulator width (sign- or zero-extension).
  function automatic logic signed [ACC_W-1:0] ext_prod(input logic [PW-1:0] p,
                                                       input logic s);
    logic signed [ACC_W-1:0] r;
    if (s) r = ACC_W'($signed(p));
    else   r = ACC_W'(p);
    return r;
  endfunction

  // Accumulate with overflow flag in bit ACC_W; clamps when saturation is built in.
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] x,
                                             input logic signed [ACC_W-1:0] y,
                                             input logic s);
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] r;
    logic             o;
    wide = {1'b0, x} + {1'b0, y};
    r    = wide[ACC_W-1:0];
    if (s) o = (x[ACC_W-1] == y[ACC_W-1]) && (r[ACC_W-1] != x[ACC_W-1]);
    else   o = wide[ACC_W];
`ifdef MAC_DOT_SAT_EN
    if (o) begin
      if (!s)             r = '1;
      else if (x[ACC_W-1]) r = {1'b1, {(ACC_W-1){1'b0}}};
      else                r = {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    return {o, r};
  endfunction

  logic                    rdy;
  logic                    pend;
  logic                    pend_n;
  logic                    first;
  logic                    mode;
  logic                    accept;
  logic                    hs;
  logic                    sgn_in;

  logic [PW-1:0]           prod_p1 [LANES];
  logic                    vld_p1;
  logic                    last_p1;
  logic                    first_p1;
  logic                    sgn_p1;

  logic signed [ACC_W-1:0] tree_sum;
  logic [ACC_W:0]          add_res;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  logic                    out_vld;

  assign accept = bus.in_valid && rdy;
  assign hs     = out_vld && bus.out_ready;
  assign sgn_in = first ? bus.in_signed : mode;
  // A vector is pending from its last beat until its result handshakes.
  assign pend_n = (pend && !hs) || (accept && bus.in_last);

  // Input-side control: vector framing, latched mode, backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy   <= 1'b0;
      pend  <= 1'b0;
      first <= 1'b1;
      mode  <= 1'b0;
    end else begin
      pend <= pend_n;
      rdy  <= !pend_n;
      if (accept) begin
        first <= bus.in_last;
        if (first) mode <= bus.in_signed;
      end
    end
  end

  // ---- Stage 1: lane products ----
  // Register the per-lane products together with the beat's framing bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      first_p1 <= 1'b0;
      sgn_p1   <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_p1[i] <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        last_p1  <= bus.in_last;
        first_p1 <= first;
        sgn_p1   <= sgn_in;
        for (int i = 0; i < LANES; i++)
          prod_p1[i] <= mul_lane(bus.in_a[i*DATA_W +: DATA_W],
                                 bus.in_b[i*DATA_W +: DATA_W], sgn_in);
      end
    end
  end

  // ---- Stage 2: reduce and accumulate ----
  // Sum of the widened lane products for the beat in stage 2.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++)
      tree_sum = tree_sum + ext_prod(prod_p1[i], sgn_p1);
  end

  assign add_res = acc_add(acc, tree_sum, sgn_p1);

  // Accumulator, beat count, sticky overflow and result-valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      if (vld_p1) begin
        if (first_p1) begin
          acc <= tree_sum;
          cnt <= CNT_W'(1);
          ovf <= 1'b0;
        end else begin
          acc <= add_res[ACC_W-1:0];
          ovf <= ovf || add_res[ACC_W];
          cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
        end
      end
      if (vld_p1 && last_p1) out_vld <= 1'b1;
      else if (hs)           out_vld <= 1'b0;
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = out_vld;
  assign bus.out_result = acc;
  assign bus.out_count  = cnt;
  assign bus.out_ovf    = ovf;
endmodule

// File: tb/tb_mac_dot_pipe.sv
// Bench for mac_dot_pipe: directed cases plus randomized vectors scored against
// an arithmetic reference model; a narrow-accumulator instance covers overflow.
module tb_mac_dot_pipe;
  localparam int DW  = 8;
  localparam int L   = 4;
  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int AW2 = 18;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_dot_pipe_if #(.DATA_W(DW), .LANES(L), .ACC_W(AW),  .CNT_W(CW)) bus ();
  mac_dot_pipe_if #(.DATA_W(DW), .LANES(L), .ACC_W(AW2), .CNT_W(CW)) bus2 ();

  mac_dot_pipe #(.DATA_W(DW), .LANES(L), .ACC_W(AW),  .CNT_W(CW)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mac_dot_pipe #(.DATA_W(DW), .LANES(L), .ACC_W(AW2), .CNT_W(CW)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] res;
    int            cnt;
    bit            ovf;
    int            t_last;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state for the main instance
  longint m_acc;
  int     m_cnt;
  bit     m_ovf;
  bit     m_sgn;
  bit     m_first = 1'b1;
  int     n_pushed = 0;
  int     n_results = 0;
  int     rdy_mode = 1;

  function automatic longint lane(input logic [7:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint beat_sum(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sum = 0;
    for (int i = 0; i < L; i++) sum += lane(a[i*8 +: 8], s) * lane(b[i*8 +: 8], s);
    return sum;
  endfunction

  // Add in exact integers, then wrap or clamp into the w-bit range of the mode.
  task automatic model_add(inout longint acc, input longint sum, input bit s,
                           input int w, inout bit ovf);
    longint m, lo, hi, r;
    m  = longint'(1) <<< w;
    lo = s ? -(m / 2) : 0;
    hi = s ? (m / 2 - 1) : (m - 1);
    r  = acc + sum;
    if (r > hi || r < lo) begin
      ovf = 1'b1;
`ifdef MAC_DOT_SAT_EN
      r = (r > hi) ? hi : lo;
`else
      r = ((r - lo) % m + m) % m + lo;
`endif
    end
    acc = r;
  endtask

  // Present one beat on the main instance; returns one cycle after acceptance.
  task automatic beat(input logic [31:0] a, input logic [31:0] b, input bit last, input bit s);
    int g = 0;
    exp_t e;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_last = last; bus.in_signed = s;
    while (!bus.in_ready && g < 100) begin @(posedge clk); #1; g++; end
    if (!bus.in_ready) begin
      chk("accept_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (m_first) begin
      m_sgn = s; m_acc = beat_sum(a, b, s); m_cnt = 1; m_ovf = 1'b0;
    end else begin
      model_add(m_acc, beat_sum(a, b, m_sgn), m_sgn, AW, m_ovf);
      if (m_cnt < 65535) m_cnt++;
    end
    m_first = last;
    if (last) begin
      e.res = m_acc[AW-1:0]; e.cnt = m_cnt; e.ovf = m_ovf; e.t_last = cyc;
      exp_q.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_vec(input int n, input bit s, input bit gaps);
    for (int k = 0; k < n; k++) begin
      beat($urandom, $urandom, (k == n - 1), (k == 0) ? s : bit'($urandom_range(0, 1)));
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() > 0 || bus.out_valid) && g < 300) begin @(posedge clk); #1; g++; end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // out_ready policy: 0 random, 1 always ready, 2 stalled
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'($urandom_range(0, 1));
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: ordering, latency, hold-under-stall and backpressure rules.
  initial begin
    bit pv = 0, pr = 0, phs = 0;
    logic [AW-1:0] pres; logic [CW-1:0] pcnt; logic povf;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0; pr = 0; phs = 0;
      end else begin
        if (phs) chk("rdy_after_hs", bus.in_ready, 1);
        if (pv && !pr) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_result", bus.out_result, pres);
          chk("hold_count", bus.out_count, pcnt);
          chk("hold_ovf", bus.out_ovf, povf);
        end
        if (bus.out_valid) begin
          chk("busy_in_ready", bus.in_ready, 0);
          if (!pv || phs) begin
            if (exp_q.size() == 0) chk("unexpected_result", bus.out_valid, 0);
            else                   chk("latency", cyc - exp_q[0].t_last, 1);
          end
          if (bus.out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("result", bus.out_result, e.res);
            chk("count", bus.out_count, e.cnt);
            chk("ovf", bus.out_ovf, e.ovf);
            n_results++;
          end
        end
        phs = bus.out_valid && bus.out_ready;
        pv = bus.out_valid; pr = bus.out_ready;
        pres = bus.out_result; pcnt = bus.out_count; povf = bus.out_ovf;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    longint a2; bit o2;
    reset = 1'b1; rdy_mode = 1;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 0; bus.in_signed = 0;
    bus2.in_valid = 0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_last = 0; bus2.in_signed = 0;
    bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_count", bus.out_count, 0);
    chk("rst_ovf", bus.out_ovf, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_reset", bus.in_ready, 1);

    // unsigned 2-beat vector of all 2s
    beat(32'h02020202, 32'h02020202, 0, 0);
    beat(32'h02020202, 32'h02020202, 1, 0);
    drain();

    // signed single-beat vector
    beat({8'hFD, 8'h04, 8'hFF, 8'h7F}, {8'h05, 8'hFE, 8'h80, 8'h01}, 1, 1);
    drain();

    // result held under a 5-cycle stall
    rdy_mode = 2;
    send_vec(3, 1, 0);
    g = 0;
    while (!bus.out_valid && g < 20) begin @(posedge clk); #1; g++; end
    chk("stall_valid", bus.out_valid, 1);
    idle(5);
    chk("stall_in_ready", bus.in_ready, 0);
    rdy_mode = 1;
    drain();

    // reset in the middle of a vector discards it
    beat($urandom, $urandom, 0, 0);
    beat($urandom, $urandom, 0, 0);
    reset = 1'b1;
    #1;
    chk("async_rst_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_first = 1'b1;
    @(posedge clk); #1;
    beat(32'h01010101, 32'h01010101, 1, 0);
    drain();

    // back-to-back 3-beat vectors with gaps, then randomized traffic
    send_vec(3, 0, 1);
    send_vec(3, 1, 1);
    rdy_mode = 0;
    for (int v = 0; v < 40; v++) send_vec($urandom_range(1, 5), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    rdy_mode = 1;
    drain();
    chk("result_total", n_results, n_pushed);

    // narrow accumulator: unsigned overflow on 3 beats of 255s
    a2 = beat_sum(32'hFFFFFFFF, 32'hFFFFFFFF, 0); o2 = 0;
    model_add(a2, beat_sum(32'hFFFFFFFF, 32'hFFFFFFFF, 0), 0, AW2, o2);
    model_add(a2, beat_sum(32'hFFFFFFFF, 32'hFFFFFFFF, 0), 0, AW2, o2);
    bus2.in_a = 32'hFFFFFFFF; bus2.in_b = 32'hFFFFFFFF; bus2.in_signed = 0;
    for (int k = 0; k < 3; k++) begin
      bus2.in_valid = 1; bus2.in_last = (k == 2);
      g = 0;
      while (!bus2.in_ready && g < 50) begin @(posedge clk); #1; g++; end
      @(posedge clk); #1;
    end
    bus2.in_valid = 0;
    g = 0;
    while (!bus2.out_valid && g < 20) begin @(posedge clk); #1; g++; end
    chk("narrow_valid", bus2.out_valid, 1);
    chk("narrow_result", bus2.out_result, a2[AW2-1:0]);
    chk("narrow_count", bus2.out_count, 3);
    chk("narrow_ovf", bus2.out_ovf, o2);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
